fc_argmax_classifier: RTL and testbench

//  Reader end of the biased fully-connected score interface: consumes the 10 biased class

---
 rtl/cnn_pkg.sv | 14 +
 rtl/signed_max_cmp.sv | 12 +
 rtl/fc_argmax_classifier.sv | 110 +++++++++++
 tb/tb_fc_argmax_classifier.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN classifier constants and the argmax FSM state encoding.
package cnn_pkg;

    localparam int W1          = 64;
    localparam int NUM_CLASSES = 10;
    localparam int CLS_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/signed_max_cmp.sv
// Full-width signed strict greater-than comparator used by the argmax scan.
module signed_max_cmp #(
    parameter int W1 = 64
) (
    input  logic signed [W1-1:0] a,
    input  logic signed [W1-1:0] b,
    output logic                 gt
);

    assign gt = (a > b);

endmodule

// File: rtl/fc_argmax_classifier.sv
// Argmax over one frame of biased FC scores; returns the winning class index.
// Optional macro FC_ARGMAX_SCORE_OUT_EN exposes the winning score on m_score.
module fc_argmax_classifier #(
    parameter int W1          = cnn_pkg::W1,
    parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
    parameter int CLS_W       = cnn_pkg::CLS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [W1-1:0] s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CLS_W-1:0]     m_class,
    output logic                 m_err
`ifdef FC_ARGMAX_SCORE_OUT_EN
    ,
    output logic signed [W1-1:0] m_score
`endif
);

    import cnn_pkg::*;

    state_t               state;
    state_t               state_next;
    logic [CLS_W-1:0]     cnt;
    logic [CLS_W-1:0]     idx;
    logic signed [W1-1:0] best;
    logic                 gt;
    logic                 beat_fire;
    logic                 last_beat;
    logic                 frame_end;
    logic                 take;

    signed_max_cmp #(.W1(W1)) u_cmp (
        .a  (s_data),
        .b  (best),
        .gt (gt)
    );

    assign beat_fire = s_valid & s_ready;
    assign last_beat = (cnt == CLS_W'(NUM_CLASSES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first beat of a frame always loads; later beats load only on a strict win,
    // so ties keep the lower index.
    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE, SCAN: begin
                if (beat_fire) begin
                    frame_end  = s_last | last_beat;
                    take       = (state == IDLE) | gt;
                    state_next = frame_end ? HOLD : SCAN;
                end
            end
            HOLD: begin
                if (m_valid && m_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            best    <= '0;
            m_err   <= 1'b0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            s_ready <= (state_next != HOLD);
            m_valid <= (state_next == HOLD);
            if (beat_fire) begin
                cnt <= frame_end ? '0 : cnt + 1'b1;
            end
            if (take) begin
                best <= s_data;
                idx  <= cnt;
            end
            // Length error: s_last and the final class beat must land together.
            if (beat_fire && frame_end) begin
                m_err <= s_last ^ last_beat;
            end
        end
    end

    assign m_class = idx;

`ifdef FC_ARGMAX_SCORE_OUT_EN
    assign m_score = best;
`else
    // best remains internal as the running maximum only.
`endif

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Scoreboard bench for fc_argmax_classifier: directed frames, backpressure, length errors, resets.
module tb_fc_argmax_classifier;

    import cnn_pkg::*;

    localparam int W = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] s_data;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [CLS_W-1:0]    m_class;
    logic                m_err;
`ifdef FC_ARGMAX_SCORE_OUT_EN
    logic signed [W-1:0] m_score;
`endif

    typedef struct packed {
        logic [CLS_W-1:0] cls;
        logic             err;
        logic [W-1:0]     score;
    } exp_t;

    exp_t                sb[$];
    exp_t                mon_exp;
    int                  total    = 0;
    int                  pass_cnt = 0;
    logic signed [W-1:0] scores [NUM_CLASSES];

    fc_argmax_classifier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_class (m_class),
        .m_err   (m_err)
`ifdef FC_ARGMAX_SCORE_OUT_EN
        ,
        .m_score (m_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Results are compared at the handshake, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                $error("[TB] FAIL unexpected_result: observed class %0d with empty scoreboard", m_class);
            end else begin
                mon_exp = sb.pop_front();
                check_output("m_class", W'(m_class), W'(mon_exp.cls));
                check_output("m_err", W'(m_err), W'(mon_exp.err));
`ifdef FC_ARGMAX_SCORE_OUT_EN
                check_output("m_score", m_score, mon_exp.score);
`endif
            end
        end
    end

    // Called at a drive point (just after a rising edge); returns at the next drive point after transfer.
    task automatic apply_stimulus(input logic signed [W-1:0] d, input logic last);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && waited < 50) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            total++;
            $error("[TB] FAIL beat_accept: s_ready observed 0 required 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int last_pos, input int max_gap);
        int                  n;
        logic signed [W-1:0] best;
        exp_t                e;
        n    = (last_pos >= 0) ? last_pos + 1 : NUM_CLASSES;
        best = scores[0];
        e.cls = '0;
        for (int i = 1; i < n; i++) begin
            if (scores[i] > best) begin
                best  = scores[i];
                e.cls = CLS_W'(i);
            end
        end
        e.err   = (last_pos != NUM_CLASSES - 1);
        e.score = best;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    s_data = W'({$urandom, $urandom});
                    @(posedge clk);
                    #1;
                end
            end
            apply_stimulus(scores[i], (i == last_pos));
        end
        @(negedge clk);
        check_output("latency_m_valid", W'(m_valid), W'(1'b1));
        check_output("hold_s_ready", W'(s_ready), W'(1'b0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        #2;
        check_output("rst_s_ready", W'(s_ready), W'(1'b0));
        check_output("rst_m_valid", W'(m_valid), W'(1'b0));
        check_output("rst_m_class", W'(m_class), W'(0));
        check_output("rst_m_err", W'(m_err), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("s_ready_after_rst", W'(s_ready), W'(1'b1));

        $display("[TB] basic frame with tie");
        scores = '{64'sd3, -64'sd7, 64'sd12, 64'sd0, 64'sd5, 64'sd12, -64'sd1, 64'sd4, 64'sd9, 64'sd2};
        send_frame(9, 0);

        $display("[TB] all negative");
        scores = '{-64'sd100, -64'sd50, -64'sd51, -64'sd60, -64'sd70,
                   -64'sd80, -64'sd90, -64'sd100, -64'sd150, -64'sd200};
        send_frame(9, 0);

        $display("[TB] backpressure");
        scores = '{64'sd1, 64'sd2, 64'sd3, 64'sd4, 64'sd5, 64'sd6, 64'sd7, 64'sd8, 64'sd99, 64'sd9};
        m_ready = 1'b0;
        send_frame(9, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("bp_m_valid", W'(m_valid), W'(1'b1));
            check_output("bp_m_class", W'(m_class), W'(8));
            check_output("bp_s_ready", W'(s_ready), W'(1'b0));
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_release_s_ready", W'(s_ready), W'(1'b1));
        check_output("bp_release_m_valid", W'(m_valid), W'(1'b0));
        scores = '{64'sd9, 64'sd2, 64'sd3, 64'sd4, 64'sd5, 64'sd6, 64'sd7, 64'sd8, 64'sd1, 64'sd50};
        send_frame(9, 0);

        $display("[TB] length errors");
        scores = '{64'sd0, 64'sd1, 64'sd2, 64'sd3, 64'sd40, 64'sd5, 64'sd6, 64'sd0, 64'sd0, 64'sd0};
        send_frame(6, 0);
        scores = '{64'sd7, 64'sd7, 64'sd7, 64'sd7, 64'sd7, 64'sd7, 64'sd7, 64'sd8, 64'sd7, 64'sd7};
        send_frame(-1, 0);
        scores = '{-64'sd5, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0};
        send_frame(0, 0);

        $display("[TB] extremes with gaps");
        scores = '{64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0, 64'sd0,
                   64'sh7FFF_FFFF_FFFF_FFFF, 64'sh8000_0000_0000_0000, 64'sd0};
        send_frame(9, 3);
        scores = '{64'sd4, 64'sd4, 64'sd4, 64'sd4, 64'sd4, 64'sd4, 64'sd4, 64'sd4, 64'sd4, 64'sd4};
        send_frame(9, 2);

        $display("[TB] reset mid-frame");
        apply_stimulus(64'sd1, 1'b0);
        apply_stimulus(64'sd2, 1'b0);
        apply_stimulus(64'sd3, 1'b0);
        apply_stimulus(64'sd1000, 1'b0);
        rst_n = 1'b0;
        #1;
        check_output("midrst_s_ready", W'(s_ready), W'(1'b0));
        check_output("midrst_m_valid", W'(m_valid), W'(1'b0));
        check_output("midrst_m_class", W'(m_class), W'(0));
        check_output("midrst_m_err", W'(m_err), W'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        scores = '{64'sd5, 64'sd4, 64'sd3, 64'sd2, 64'sd1, 64'sd0, -64'sd1, -64'sd2, -64'sd3, -64'sd4};
        send_frame(9, 0);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        check_output("sb_drained", W'(sb.size()), W'(0));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
